gb_read_streamer: RTL and testbench

- Downstream read stage of the global buffer: accepts a (base, length) line-read command and issues one global-buffer line read per cycle.
- Absorbs the fixed read latency in a small output FIFO and streams lines to the PE-array scatter logic over valid/ready.
- Issue is credit-gated so backpressure never overflows the FIFO or drops returned data.

---
 rtl/gb_read_streamer_if.sv | 34 +++
 rtl/gb_read_streamer.sv | 192 +++++++++++++++++++
 tb/tb_gb_read_streamer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_read_streamer_if.sv
// Bus bundle for gb_read_streamer: command, global-buffer read and output stream.
// master = the streamer itself, slave = the surrounding fabric / testbench.
interface gb_read_streamer_if #(
    parameter int AW    = 6,
    parameter int LW    = 128,
    parameter int LEN_W = 8
);
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [AW-1:0]    cmd_base_i;
    logic [LEN_W-1:0] cmd_len_i;
    logic             gb_rd_en_o;
    logic [AW-1:0]    gb_addr_o;
    logic [LW-1:0]    gb_rd_data_i;
    logic             gb_valid_i;
    logic [LW-1:0]    out_data_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             out_last_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        input  cmd_valid_i, cmd_base_i, cmd_len_i, gb_rd_data_i, gb_valid_i, out_ready_i,
        output cmd_ready_o, gb_rd_en_o, gb_addr_o, out_data_o, out_valid_o, out_last_o,
               busy_o, done_o
    );

    modport slave (
        output cmd_valid_i, cmd_base_i, cmd_len_i, gb_rd_data_i, gb_valid_i, out_ready_i,
        input  cmd_ready_o, gb_rd_en_o, gb_addr_o, out_data_o, out_valid_o, out_last_o,
               busy_o, done_o
    );
endinterface

// File: rtl/gb_read_streamer.sv
// gb_read_streamer: takes a (base, length) line-read command, issues one
// global-buffer line read per cycle under FIFO credit, and streams the returned
// lines out over valid/ready with a last tag and a done pulse.
// Optional macro GB_STREAM_PERF_EN adds a saturating 32-bit stall counter.
module gb_read_streamer #(
    parameter int DATA_SIZE  = 8,
    parameter int IF_DEPTH   = 16,
    parameter int GB_DEPTH   = 1024,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8,
    localparam int NL = GB_DEPTH / IF_DEPTH,
    localparam int AW = $clog2(NL),
    localparam int LW = IF_DEPTH * DATA_SIZE
) (
    input  logic clk,
    input  logic rst,
    gb_read_streamer_if.master bus
`ifdef GB_STREAM_PERF_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    // Pointer / occupancy widths; outstanding never exceeds FIFO_DEPTH but is
    // sized with room for a full latency window.
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(FIFO_DEPTH + RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued_q;
    logic [LEN_W-1:0] ret_cnt_q;
    logic [AW-1:0]    next_addr_q;
    logic [OW-1:0]    outst_q;
    logic             rd_en_p1;
    logic [AW-1:0]    addr_p1;
    logic             done_q;

    logic [LW-1:0]    fifo_data [FIFO_DEPTH];
    logic             fifo_last [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    fifo_cnt_q;

    logic             accept, credit, issue_now, last_issue, done_set;
    logic [AW-1:0]    issue_addr;
    logic             push, pop, push_last, head_last, out_valid;

    // Line address successor with wrap from NL-1 back to 0.
    function automatic logic [AW-1:0] next_line(input logic [AW-1:0] a);
        return (a == AW'(NL - 1)) ? '0 : a + AW'(1);
    endfunction

    assign accept    = (state_q == IDLE) && bus.cmd_valid_i;
    assign credit    = (32'(outst_q) + 32'(fifo_cnt_q)) < FIFO_DEPTH;
    assign push      = bus.gb_valid_i && (outst_q != '0);
    assign push_last = (ret_cnt_q == (len_q - LEN_W'(1)));
    assign out_valid = (fifo_cnt_q != '0);
    assign pop       = out_valid && bus.out_ready_i;
    assign head_last = fifo_last[rd_ptr_q];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: IDLE -> ISSUE/DRAIN on a non-empty command, ISSUE -> DRAIN
    // after the final line is issued, DRAIN -> IDLE on the last output handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && (bus.cmd_len_i != '0)) state_d = last_issue ? DRAIN : ISSUE;
            ISSUE:   if (issue_now && last_issue) state_d = DRAIN;
            DRAIN:   if (done_set) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: issue decision (first line is issued straight from IDLE) and done request.
    always_comb begin
        issue_now  = 1'b0;
        issue_addr = next_addr_q;
        last_issue = 1'b0;
        done_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.cmd_len_i == '0) begin
                        done_set = 1'b1;
                    end else begin
                        issue_now  = 1'b1;
                        issue_addr = bus.cmd_base_i;
                        last_issue = (bus.cmd_len_i == LEN_W'(1));
                    end
                end
            end
            ISSUE: begin
                if (credit) begin
                    issue_now  = 1'b1;
                    last_issue = (issued_q == (len_q - LEN_W'(1)));
                end
            end
            DRAIN:   done_set = pop && head_last;
            default: ;
        endcase
    end

    // Issue stage -> registered read strobe / address, command counters, credit tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_p1    <= 1'b0;
            addr_p1     <= '0;
            next_addr_q <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            ret_cnt_q   <= '0;
            outst_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            rd_en_p1 <= issue_now;
            done_q   <= done_set;
            if (issue_now) begin
                addr_p1     <= issue_addr;
                next_addr_q <= next_line(issue_addr);
            end
            if (accept) begin
                len_q     <= bus.cmd_len_i;
                issued_q  <= (bus.cmd_len_i != '0) ? LEN_W'(1) : '0;
                ret_cnt_q <= '0;
            end else begin
                if (issue_now) issued_q  <= issued_q + LEN_W'(1);
                if (push)      ret_cnt_q <= ret_cnt_q + LEN_W'(1);
            end
            case ({issue_now, push})
                2'b10:   outst_q <= outst_q + OW'(1);
                2'b01:   outst_q <= outst_q - OW'(1);
                default: outst_q <= outst_q;
            endcase
        end
    end

    // Return stage -> FIFO storage; line payload and last tag are written only.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= bus.gb_rd_data_i;
            fifo_last[wr_ptr_q] <= push_last;
        end
    end

    // FIFO pointers and occupancy; push and pop in the same cycle keep the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

`ifdef GB_STREAM_PERF_EN
    logic stall_evt;
    assign stall_evt = (out_valid && !bus.out_ready_i) || ((state_q == ISSUE) && !credit);

    // Stall counter: output backpressure or credit-blocked issue, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  stall_cnt_o <= '0;
        else if (accept)                          stall_cnt_o <= '0;
        else if (stall_evt && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

    assign bus.cmd_ready_o = (state_q == IDLE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.done_o      = done_q;
    assign bus.gb_rd_en_o  = rd_en_p1;
    assign bus.gb_addr_o   = addr_p1;
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_valid ? fifo_data[rd_ptr_q] : '0;
    assign bus.out_last_o  = out_valid && head_last;

endmodule

// File: tb/tb_gb_read_streamer.sv
// Directed bench for gb_read_streamer with a global-buffer model and a
// scoreboard of expected read addresses and output lines.
module tb_gb_read_streamer;
    localparam int DATA_SIZE  = 8;
    localparam int IF_DEPTH   = 16;
    localparam int GB_DEPTH   = 1024;
    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int LEN_W      = 8;
    localparam int NL = GB_DEPTH / IF_DEPTH;
    localparam int AW = $clog2(NL);
    localparam int LW = IF_DEPTH * DATA_SIZE;

    typedef logic [LW:0] val_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gb_read_streamer_if #(.AW(AW), .LW(LW), .LEN_W(LEN_W)) bus ();
`ifdef GB_STREAM_PERF_EN
    logic [31:0] stall_cnt;
`endif

    gb_read_streamer #(
        .DATA_SIZE(DATA_SIZE), .IF_DEPTH(IF_DEPTH), .GB_DEPTH(GB_DEPTH),
        .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef GB_STREAM_PERF_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    logic [AW-1:0] addr_q [$];
    val_t          exp_q  [$];

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        logic [LW-1:0] r;
        for (int i = 0; i < IF_DEPTH; i++)
            r[i*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'(int'(a) * 3 + i * 17 + 'h5A);
        return r;
    endfunction

    task automatic chk(input string tag, input val_t obs, input val_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Global-buffer model: fixed RD_LAT return of the addressed line.
    logic          vpipe [RD_LAT];
    logic [LW-1:0] dpipe [RD_LAT];
    always @(posedge clk) begin
        vpipe[0] <= bus.gb_rd_en_o;
        dpipe[0] <= line_of(bus.gb_addr_o);
        for (int i = 1; i < RD_LAT; i++) begin
            vpipe[i] <= vpipe[i-1];
            dpipe[i] <= dpipe[i-1];
        end
    end
    assign bus.gb_valid_i   = vpipe[RD_LAT-1];
    assign bus.gb_rd_data_i = dpipe[RD_LAT-1];

    // Monitor: read addresses, output lines in order, head stability under stall.
    int   rd_cnt = 0;
    logic hold_pending = 1'b0;
    val_t hold_val;
    always @(negedge clk) begin
        if (rst) begin
            hold_pending <= 1'b0;
        end else begin
            if (hold_pending) begin
                chk_i("hold_valid", int'(bus.out_valid_o), 1);
                chk("hold_line", {bus.out_last_o, bus.out_data_o}, hold_val);
            end
            hold_pending <= bus.out_valid_o && !bus.out_ready_i;
            hold_val     <= {bus.out_last_o, bus.out_data_o};
            if (bus.gb_rd_en_o) begin
                rd_cnt <= rd_cnt + 1;
                chk_i("read_expected", int'(addr_q.size() != 0), 1);
                if (addr_q.size() != 0) chk_i("gb_addr", int'(bus.gb_addr_o), int'(addr_q.pop_front()));
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                chk_i("out_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("out_line", {bus.out_last_o, bus.out_data_o}, exp_q.pop_front());
            end
        end
    end

    task automatic send_cmd(input int base, input int len);
        logic [AW-1:0] a;
        for (int i = 0; i < len; i++) begin
            a = AW'((base + i) % NL);
            addr_q.push_back(a);
            exp_q.push_back({(i == len - 1), line_of(a)});
        end
        bus.cmd_base_i  = AW'(base);
        bus.cmd_len_i   = LEN_W'(len);
        bus.cmd_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!bus.done_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_i({tag, "_done_seen"}, int'(bus.done_o), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        int n;
        rst = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_base_i  = '0;
        bus.cmd_len_i   = '0;
        bus.out_ready_i = 1'b0;

        // Reset state
        @(negedge clk);
        chk_i("rst_cmd_ready", int'(bus.cmd_ready_o), 1);
        chk_i("rst_rd_en", int'(bus.gb_rd_en_o), 0);
        chk_i("rst_addr", int'(bus.gb_addr_o), 0);
        chk_i("rst_out_valid", int'(bus.out_valid_o), 0);
        chk("rst_out_line", {bus.out_last_o, bus.out_data_o}, '0);
        chk_i("rst_busy", int'(bus.busy_o), 0);
        chk_i("rst_done", int'(bus.done_o), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic stream: base 5, len 3, cycle-exact timing
        bus.out_ready_i = 1'b1;
        send_cmd(5, 3);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk_i($sformatf("basic_rd_en_t%0d", k), int'(bus.gb_rd_en_o), int'(k <= 3));
            chk_i($sformatf("basic_out_valid_t%0d", k), int'(bus.out_valid_o), int'(k >= 3 && k <= 5));
            chk_i($sformatf("basic_out_last_t%0d", k), int'(bus.out_last_o), int'(k == 5));
            chk_i($sformatf("basic_done_t%0d", k), int'(bus.done_o), int'(k == 6));
            chk_i($sformatf("basic_cmd_ready_t%0d", k), int'(bus.cmd_ready_o), int'(k == 6));
        end
        @(negedge clk);
        chk_i("basic_done_one_cycle", int'(bus.done_o), 0);
        chk_i("basic_sb_empty", exp_q.size(), 0);

        // Backpressure: base 0, len 10, consumer stalled
        @(posedge clk);
        #1 bus.out_ready_i = 1'b0;
        rc0 = rd_cnt;
        send_cmd(0, 10);
        repeat (12) @(negedge clk);
        chk_i("bp_reads_credit", rd_cnt - rc0, 4);
        chk_i("bp_rd_en_blocked", int'(bus.gb_rd_en_o), 0);
        chk_i("bp_out_valid", int'(bus.out_valid_o), 1);
        chk_i("bp_busy", int'(bus.busy_o), 1);
        @(posedge clk);
        #1 bus.out_ready_i = 1'b1;
        wait_done("bp", 60);
        chk_i("bp_reads_total", rd_cnt - rc0, 10);
        chk_i("bp_sb_empty", exp_q.size(), 0);

        // Wrap: base 62, len 4 -> 62,63,0,1
        @(posedge clk);
        #1;
        send_cmd(62, 4);
        wait_done("wrap", 30);
        chk_i("wrap_addr_empty", addr_q.size(), 0);
        chk_i("wrap_sb_empty", exp_q.size(), 0);

        // Zero length
        @(posedge clk);
        #1;
        rc0 = rd_cnt;
        send_cmd(7, 0);
        @(negedge clk);
        chk_i("zero_done", int'(bus.done_o), 1);
        chk_i("zero_cmd_ready", int'(bus.cmd_ready_o), 1);
        chk_i("zero_busy", int'(bus.busy_o), 0);
        @(negedge clk);
        chk_i("zero_done_pulse", int'(bus.done_o), 0);
        repeat (3) @(negedge clk);
        chk_i("zero_no_reads", rd_cnt - rc0, 0);

        // Reset mid-stream with one read in flight
        @(posedge clk);
        #1;
        send_cmd(40, 8);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        addr_q.delete();
        exp_q.delete();
        #1;
        chk_i("mrst_rd_en", int'(bus.gb_rd_en_o), 0);
        chk_i("mrst_addr", int'(bus.gb_addr_o), 0);
        chk_i("mrst_out_valid", int'(bus.out_valid_o), 0);
        chk("mrst_out_line", {bus.out_last_o, bus.out_data_o}, '0);
        chk_i("mrst_busy", int'(bus.busy_o), 0);
        chk_i("mrst_cmd_ready", int'(bus.cmd_ready_o), 1);
        @(negedge clk);
        chk_i("mrst_late_data_present", int'(bus.gb_valid_i), 1);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_i("mrst_late_dropped", int'(bus.out_valid_o), 0);
        chk_i("mrst_no_done", int'(bus.done_o), 0);
        repeat (3) @(negedge clk);
        chk_i("mrst_still_empty", int'(bus.out_valid_o), 0);
        @(posedge clk);
        #1;
        send_cmd(20, 2);
        wait_done("mrst_new", 20);
        chk_i("mrst_sb_empty", exp_q.size(), 0);

`ifdef GB_STREAM_PERF_EN
        // Perf: 5 stalled cycles on the output
        @(posedge clk);
        #1 bus.out_ready_i = 1'b0;
        send_cmd(9, 2);
        n = 0;
        while (!bus.out_valid_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk_i("perf_out_valid_seen", int'(bus.out_valid_o), 1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 bus.out_ready_i = 1'b1;
        wait_done("perf", 20);
        chk_i("perf_stall_cnt", int'(stall_cnt), 5);
        chk_i("perf_sb_empty", exp_q.size(), 0);
`endif

        n = 0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
